// File: rtl/cla_share_pkg.sv
// rtl/cla_share_pkg.sv - shared types and constants for the CLA share arbiter
package cla_share_pkg;

  localparam int DATA_W = 8;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/CLA_8bit.sv
// rtl/CLA_8bit.sv - 8-bit carry-lookahead adder/subtractor (Add_ctrl=1 add, 0 subtract)
module CLA_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Add_ctrl,
  output logic [7:0] SUM,
  output logic       C_out,
  output logic       v
);

  logic [7:0] b_eff;
  logic [7:0] p;
  logic [7:0] g;
  logic [8:0] c;

  assign b_eff = Add_ctrl ? B : ~B;
  assign p     = A ^ b_eff;
  assign g     = A & b_eff;

  // Subtract is A + ~B + 1, so carry-in is the inverse of Add_ctrl.
  always_comb begin
    c    = '0;
    c[0] = ~Add_ctrl;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign SUM   = p ^ c[7:0];
  assign C_out = c[8];
  assign v     = c[8] ^ c[7];

endmodule

// File: rtl/cla_share_arbiter_rr_grant.sv
// rtl/cla_share_arbiter_rr_grant.sv - combinational round-robin picker starting at ptr
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  // Walk from the farthest offset down so the nearest requester at or after ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IDW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cla_share_arbiter.sv
// rtl/cla_share_arbiter.sv - round-robin sharing of one CLA_8bit among NREQ requesters
// Optional per-requester grant counters under CLA_SHARE_STATS_EN.
module cla_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  parameter int IDW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*8-1:0]    req_a,
  input  logic [NREQ*8-1:0]    req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_v,
  output logic                 busy
`ifdef CLA_SHARE_STATS_EN
  , output logic [NREQ*16-1:0] grant_cnt
`endif
);

  import cla_share_pkg::*;

  localparam int CNT_W = 4;

  state_t              state_r;
  state_t              state_nx;
  logic [IDW-1:0]      ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic                op_r;
  logic [IDW-1:0]      id_r;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      win_idx;
  logic                any_req;
  logic                accept;

  logic [DATA_W-1:0]   sum_w;
  logic                cout_w;
  logic                v_w;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_req)
  );

  CLA_8bit u_cla (
    .A        (a_r),
    .B        (b_r),
    .Add_ctrl (op_r),
    .SUM      (sum_w),
    .C_out    (cout_w),
    .v        (v_w)
  );

  assign accept = (state_r == IDLE) && any_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx;
  end

  always_comb begin
    state_nx  = state_r;
    req_ready = '0;
    busy      = 1'b1;
    case (state_r)
      IDLE: begin
        busy      = 1'b0;
        req_ready = grant;
        if (any_req) state_nx = WAIT;
      end
      WAIT: begin
        if (cnt_r == '0) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Operands are latched at accept so requesters are free to change them afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= '0;
      cnt_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= OP_ADD;
      id_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_v     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        a_r   <= req_a[8*win_idx +: 8];
        b_r   <= req_b[8*win_idx +: 8];
        op_r  <= req_op[win_idx];
        id_r  <= win_idx;
        cnt_r <= CNT_W'(SETTLE - 1);
        if (win_idx == IDW'(NREQ - 1)) ptr_r <= '0;
        else                           ptr_r <= win_idx + 1'b1;
      end
      if (state_r == WAIT && cnt_r != '0) begin
        cnt_r <= cnt_r - 1'b1;
      end
      if (state_r == DONE) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_r;
        rsp_sum   <= sum_w;
        rsp_cout  <= cout_w;
        rsp_v     <= v_w;
      end
    end
  end

`ifdef CLA_SHARE_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        grant_cnt[16*i +: 16] <= '0;
      end else if (accept && win_idx == IDW'(i) && grant_cnt[16*i +: 16] != 16'hFFFF) begin
        grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/cla_share_arbiter.md
Name: cla_share_arbiter

Overview:
- Shares one 8-bit carry-lookahead adder/subtractor (internal `CLA_8bit` instance) among NREQ requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Per transaction: registers the winner's operands and op, drives the adder, waits SETTLE cycles for the combinational path to settle, captures SUM/C_out/v, and returns a tagged response pulse.
- Sits between requesting control FSMs and the shared arithmetic datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETTLE, 2, cycles the adder inputs are held before capture (1..15).
- IDW, 2, width of the requester id (clog2(NREQ), minimum 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held with its operands until accepted.
- req_ready  out  NREQ  one-hot accept strobe; combinational.
- req_a  in  NREQ*8  operand A, two's complement; slice i = bits [8i+7:8i].
- req_b  in  NREQ*8  operand B, same packing.
- req_op  in  NREQ  1 = A+B, 0 = A-B (same encoding as Add_ctrl).
- rsp_valid  out  1  one-cycle result pulse.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  8  result.
- rsp_cout  out  1  adder C_out.
- rsp_v  out  1  signed overflow.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, WAIT, DONE. Reset forces IDLE.
- Outputs at reset: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_v=0, busy=0. RR pointer=0; wait counter=0; operand registers=0; op register=1.
- Grant (IDLE only): scan from ptr upward, mod NREQ. The first i with req_valid[i] wins; grant is one-hot.
- req_ready[i] = (state==IDLE) && grant[i]. Outside IDLE, req_ready=0.
- Accept edge (IDLE, any valid):
  - load a_r, b_r, op_r, id_r from the winner;
  - ptr <= (winner+1) mod NREQ;
  - counter <= SETTLE-1;
  - go to WAIT.
- IDLE with no valid: stay; ptr unchanged.
- WAIT: the adder sees a_r/b_r/op_r only. Decrement the counter each cycle; at 0, go to DONE.
- DONE edge: capture rsp_sum, rsp_cout, rsp_v and rsp_id <= id_r; set rsp_valid=1 for exactly one cycle; go to IDLE.
- Latency: accept edge at cycle T gives rsp_valid high during cycle T+SETTLE+1.
- Throughput: one transaction per SETTLE+2 cycles. A new grant is allowed in the same cycle that rsp_valid is high.
- Response fields hold their last value after rsp_valid falls.
- Subtract uses the adder's internal invert-plus-one. C_out semantics are the adder's: 0-0 gives C_out=1.
- v = signed overflow of the 8-bit result.
- Requests that drop req_valid before acceptance are simply not granted; no error.
- Operands that change after acceptance have no effect.
- Reset mid-transaction: abort immediately, no rsp_valid, ptr=0.
- The arbiter never issues req_ready to a requester whose req_valid is low.

Optional Feature:
- Macro: CLA_SHARE_STATS_EN.
- When defined: adds output `grant_cnt` (NREQ*16), one saturating 16-bit counter per requester.
  - Increments on each accept for that requester.
  - Holds at 16'hFFFF once saturated.
  - Cleared by rst.
- When undefined: no port, no counters; all other behaviour identical.

Decomposition:
- Package `cla_share_pkg`:
  - state enum (IDLE, WAIT, DONE);
  - op constants OP_ADD=1'b1, OP_SUB=1'b0;
  - DATA_W=8.
- Sub-module `rr_grant`: combinational NREQ-wide round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, binary index, any.
- The existing `CLA_8bit` is instantiated unchanged.

Test Plan (NREQ=4, SETTLE=2 unless noted):
- After reset, req0 A=2, B=3, add → req_ready[0] pulses; rsp at T+3: sum=5, cout=0, v=0, id=0.
- req1 A=127, B=127, add → sum=8'hFE, v=1, cout=0, id=1. Then A=-128, B=127, sub → sum=8'h01, cout=1, v=1.
- All four requesters hold valid continuously → grants 0,1,2,3,0,…, one grant per 4 cycles. No requester is granted twice before every other one is granted once.
- req2 alone, A=0, B=0, sub → sum=0, cout=1, v=0. With SETTLE=5, rsp_valid appears exactly 6 cycles after accept.
- Assert rst during WAIT → no rsp_valid, busy=0 next cycle. Next lone req3 is granted first, with ptr reset to 0.
- With CLA_SHARE_STATS_EN: force 65540 grants to req0 → grant_cnt[15:0] saturates at 16'hFFFF.
